// File: rtl/eclk_sync_bus.sv
// eclk_sync_bus: bridges a CPU request onto a 6800-style synchronous
// peripheral bus timed by the one-hot E-clock phase vector. The access
// window (vma/cia_sel) opens at the phase-3 sample and closes at the
// phase-9 sample, giving a 24-cycle window at 28 MHz.
module eclk_sync_bus (
  input  logic       clk_28,
  input  logic       reset_n,
  input  logic       clk7_en,
  input  logic [9:0] eclk,
  input  logic       req,
  input  logic       we,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  output logic       ack,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       vma,
  output logic       cia_sel,
  output logic       cia_we,
  output logic [3:0] cia_addr,
  output logic [7:0] cia_wdata,
  input  logic [7:0] cia_rdata,
  output logic       e_out,
  output logic       phase_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // True when exactly one of the ten E-phase bits is set.
  function automatic logic onehot10(input logic [9:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 10; i++) begin
      cnt = cnt + {3'd0, v[i]};
    end
    return (cnt == 4'd1);
  endfunction

  state_t      state_q, state_d;
  logic        accept_s;
  logic        capture_s;
  logic        vma_d, cia_sel_d, cia_we_d, ack_d, busy_d;
  logic        vma_q, cia_sel_q, cia_we_q, ack_q, busy_q;
  logic        we_lat_q;
  logic [3:0]  cia_addr_q;
  logic [7:0]  cia_wdata_q;
  logic [7:0]  rdata_q;
  logic        e_out_q;
  logic        phase_err_q;

  // Next-state and registered-output decode; only sample cycles move the FSM,
  // except the unconditional DONE->IDLE step.
  always_comb begin
    state_d   = state_q;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clk7_en && req) begin
          state_d  = ST_WAIT;
          accept_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (clk7_en) begin
          if (!req) begin
            state_d = ST_IDLE;
          end else if (eclk[3]) begin
            state_d = ST_ACTIVE;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_ACTIVE: begin
        // req is deliberately ignored here: a started bus cycle always completes.
        if (clk7_en && eclk[9]) begin
          state_d   = ST_DONE;
          capture_s = ~we_lat_q;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    vma_d     = (state_d == ST_ACTIVE);
    cia_sel_d = (state_d == ST_ACTIVE);
    cia_we_d  = (state_d == ST_ACTIVE) & we_lat_q;
    ack_d     = (state_d == ST_DONE);
    busy_d    = (state_d != ST_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk_28 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bus control outputs registered from the next state so they align with it.
  always_ff @(posedge clk_28 or negedge reset_n) begin
    if (!reset_n) begin
      vma_q     <= 1'b0;
      cia_sel_q <= 1'b0;
      cia_we_q  <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      vma_q     <= vma_d;
      cia_sel_q <= cia_sel_d;
      cia_we_q  <= cia_we_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  // Request latch at acceptance and read-data capture at the phase-9 sample.
  always_ff @(posedge clk_28 or negedge reset_n) begin
    if (!reset_n) begin
      we_lat_q    <= 1'b0;
      cia_addr_q  <= 4'd0;
      cia_wdata_q <= 8'd0;
      rdata_q     <= 8'd0;
    end else begin
      if (accept_s) begin
        we_lat_q    <= we;
        cia_addr_q  <= addr;
        cia_wdata_q <= wdata;
      end else begin
        we_lat_q    <= we_lat_q;
        cia_addr_q  <= cia_addr_q;
        cia_wdata_q <= cia_wdata_q;
      end
      if (capture_s) begin
        rdata_q <= cia_rdata;
      end else begin
        rdata_q <= rdata_q;
      end
    end
  end

  // Registered E clock and sticky phase-vector sanity flag.
  always_ff @(posedge clk_28 or negedge reset_n) begin
    if (!reset_n) begin
      e_out_q     <= 1'b0;
      phase_err_q <= 1'b0;
    end else begin
      e_out_q     <= eclk[6] | eclk[7] | eclk[8] | eclk[9];
      phase_err_q <= phase_err_q | (clk7_en & ~onehot10(eclk));
    end
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign vma       = vma_q;
  assign cia_sel   = cia_sel_q;
  assign cia_we    = cia_we_q;
  assign cia_addr  = cia_addr_q;
  assign cia_wdata = cia_wdata_q;
  assign rdata     = rdata_q;
  assign e_out     = e_out_q;
  assign phase_err = phase_err_q;

endmodule

// File: tb/tb_eclk_sync_bus.sv
// Scoreboard bench for eclk_sync_bus: the driver predicts every bus cycle from
// E-phase arithmetic and queues it; a negedge monitor pops on each ack.
module tb_eclk_sync_bus;

  logic       clk_28 = 1'b0;
  logic       reset_n = 1'b0;
  logic       clk7_en = 1'b0;
  logic [9:0] eclk = 10'h001;
  logic       req = 1'b0;
  logic       we = 1'b0;
  logic [3:0] addr = 4'h0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] cia_rdata = 8'h00;
  logic       ack, busy, vma, cia_sel, cia_we, e_out, phase_err;
  logic [7:0] rdata, cia_wdata;
  logic [3:0] cia_addr;

  eclk_sync_bus dut (
    .clk_28(clk_28), .reset_n(reset_n), .clk7_en(clk7_en), .eclk(eclk),
    .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .vma(vma), .cia_sel(cia_sel),
    .cia_we(cia_we), .cia_addr(cia_addr), .cia_wdata(cia_wdata),
    .cia_rdata(cia_rdata), .e_out(e_out), .phase_err(phase_err)
  );

  always #18 clk_28 = ~clk_28;

  typedef struct {
    int         acc;
    int         act;
    int         ack_e;
    bit         w;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] rd;
  } exp_t;

  exp_t       sbq[$];
  int         edge_cnt = 0;
  int         bad_edge = -1;
  bit         mon_ok = 1'b0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_rd = 8'h00;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_cnt);
    end
  endtask

  function automatic int next_sample(input int from);
    int e = from;
    while (e % 4 != 0) e++;
    return e;
  endfunction

  function automatic int next_p3(input int after);
    int e = after + 1;
    while (!((e % 4 == 0) && ((e / 4) % 10 == 3))) e++;
    return e;
  endfunction

  function automatic logic exp_eout(input int e);
    if (e == bad_edge) return 1'b0;
    return ((e / 4) % 10) >= 6;
  endfunction

  always @(posedge clk_28) begin
    edge_cnt <= edge_cnt + 1;
    mon_ok   <= reset_n;
  end

  // E-clock generator: edge n samples phase (n/4)%10, clk7_en on n%4==0.
  always @(negedge clk_28) begin
    int up;
    up = edge_cnt + 1;
    clk7_en = (up % 4 == 0);
    eclk = (up == bad_edge) ? 10'h003 : (10'h001 << ((up / 4) % 10));
  end

  bit   vma_prev = 1'b0;
  int   vma_len = 0;
  bit   chk_busy_next = 1'b0;
  exp_t mon_e;

  // Monitor: compares the DUT against the head of the scoreboard.
  always @(negedge clk_28) begin
    if (!(mon_ok && reset_n)) begin
      vma_prev = 1'b0;
      vma_len = 0;
      chk_busy_next = 1'b0;
    end else begin
      check("e_out", e_out, exp_eout(edge_cnt));
      if (chk_busy_next) begin
        check("busy_after_ack", busy, 0);
        chk_busy_next = 1'b0;
      end
      if (vma && !vma_prev) begin
        vma_len = 0;
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_vma: vma rose at edge %0d with nothing pending", edge_cnt);
        end else begin
          check("vma_start_edge", edge_cnt, sbq[0].act);
        end
      end
      if (vma) begin
        vma_len++;
        if (sbq.size() > 0) begin
          check("cia_sel", cia_sel, 1);
          check("busy_active", busy, 1);
          check("cia_we", cia_we, sbq[0].w);
          check("cia_addr", cia_addr, sbq[0].a);
          check("cia_wdata", cia_wdata, sbq[0].d);
        end
      end
      if (!vma && vma_prev) check("vma_window_len", vma_len, 24);
      if (ack) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: ack at edge %0d with nothing pending", edge_cnt);
        end else begin
          mon_e = sbq.pop_front();
          check("ack_edge", edge_cnt, mon_e.ack_e);
          check("rdata", rdata, mon_e.rd);
          check("vma_in_done", vma, 0);
          check("cia_sel_in_done", cia_sel, 0);
          check("cia_we_in_done", cia_we, 0);
          check("cia_addr_in_done", cia_addr, mon_e.a);
          check("latency_ok", ((edge_cnt - mon_e.acc) / 4 >= 7) && ((edge_cnt - mon_e.acc) / 4 <= 16), 1);
        end
        chk_busy_next = 1'b1;
      end
      vma_prev = vma;
    end
  end

  task automatic wait_phase_sample(input int ph);
    do @(negedge clk_28);
    while (!(((edge_cnt + 1) % 4 == 0) && (((edge_cnt + 1) / 4) % 10 == ph)));
  endtask

  // One request (nrep=2 keeps req high for a back-to-back second cycle).
  task automatic xfer(input bit w, input logic [3:0] a, input logic [7:0] d,
                      input logic [7:0] crd, input int ph, input int nrep, input bit drop_act);
    exp_t e;
    int acc, act0, seen, bound;
    if (ph >= 0) wait_phase_sample(ph);
    else repeat ($urandom_range(1, 40)) @(negedge clk_28);
    req = 1'b1; we = w; addr = a; wdata = d; cia_rdata = crd;
    acc = next_sample(edge_cnt + 1);
    act0 = next_p3(acc);
    for (int i = 0; i < nrep; i++) begin
      e.acc = acc; e.act = next_p3(acc); e.ack_e = e.act + 24;
      e.w = w; e.a = a; e.d = d;
      e.rd = w ? last_rd : crd;
      last_rd = e.rd;
      sbq.push_back(e);
      acc = next_sample(e.ack_e + 2);
    end
    seen = 0; bound = 0;
    while (seen < nrep && bound < 1000) begin
      @(negedge clk_28);
      bound++;
      if (drop_act && edge_cnt == act0 + 4) req = 1'b0;
      if (ack) begin
        seen++;
        if (seen == nrep) req = 1'b0;
      end
    end
    if (seen < nrep) begin
      checks++; errors++;
      $display("FAIL ack_timeout: saw %0d acks, required %0d", seen, nrep);
      req = 1'b0;
    end
  endtask

  initial begin
    int act_r;
    logic [3:0] ra;
    logic [7:0] rd, rw;
    bit rwe, rdrop;

    repeat (5) @(negedge clk_28);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_vma", vma, 0);
    check("rst_cia_sel", cia_sel, 0);
    check("rst_cia_we", cia_we, 0);
    check("rst_e_out", e_out, 0);
    check("rst_phase_err", phase_err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_cia_addr", cia_addr, 0);
    check("rst_cia_wdata", cia_wdata, 0);
    reset_n = 1'b1;

    // Read requested at phase 5, then write requested exactly at phase 3.
    xfer(1'b0, 4'h2, 8'h00, 8'hA5, 5, 1, 1'b0);
    xfer(1'b1, 4'hD, 8'h3C, 8'h11, 3, 1, 1'b0);

    // Request withdrawn while waiting for phase 3.
    wait_phase_sample(5);
    req = 1'b1; we = 1'b0; addr = 4'h4;
    repeat (9) @(negedge clk_28);
    check("busy_in_wait", busy, 1);
    req = 1'b0;
    repeat (8) @(negedge clk_28);
    check("busy_after_abort", busy, 0);

    // Request withdrawn mid-window, then back-to-back with req held.
    xfer(1'b0, 4'h7, 8'h00, 8'h5A, -1, 1, 1'b1);
    xfer(1'b0, 4'h9, 8'h00, 8'hC3, 0, 2, 1'b0);

    // Corrupt phase vector inside an active window.
    wait_phase_sample(1);
    bad_edge = edge_cnt + 1 + 16;
    check("phase_err_before", phase_err, 0);
    xfer(1'b1, 4'h1, 8'h77, 8'h00, 2, 1, 1'b0);
    check("phase_err_set", phase_err, 1);
    repeat (60) @(negedge clk_28);
    check("phase_err_sticky", phase_err, 1);

    for (int n = 0; n < 12; n++) begin
      rwe = 1'($urandom_range(0, 1));
      ra = 4'($urandom);
      rw = 8'($urandom);
      rd = 8'($urandom);
      rdrop = 1'($urandom_range(0, 1));
      xfer(rwe, ra, rw, rd, -1, 1, rdrop);
    end

    // Reset pulse in the middle of an active read.
    wait_phase_sample(5);
    req = 1'b1; we = 1'b0; addr = 4'hB; wdata = 8'h00; cia_rdata = 8'hEE;
    act_r = next_p3(edge_cnt + 1);
    sbq.push_back('{edge_cnt + 1, act_r, act_r + 24, 1'b0, 4'hB, 8'h00, 8'hEE});
    while (edge_cnt < act_r + 8) @(negedge clk_28);
    reset_n = 1'b0;
    sbq.delete();
    req = 1'b0;
    #1;
    check("arst_vma", vma, 0);
    check("arst_cia_sel", cia_sel, 0);
    check("arst_busy", busy, 0);
    check("arst_ack", ack, 0);
    check("arst_phase_err", phase_err, 0);
    check("arst_cia_addr", cia_addr, 0);
    check("arst_rdata", rdata, 0);
    last_rd = 8'h00;
    repeat (3) @(negedge clk_28);
    reset_n = 1'b1;
    repeat (100) @(negedge clk_28);
    check("busy_after_reset", busy, 0);

    xfer(1'b0, 4'h3, 8'h00, 8'h96, -1, 1, 1'b0);
    repeat (10) @(negedge clk_28);
    check("scoreboard_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
